fifo_burst_arbiter: RTL and testbench

Round-robin burst scheduler that drains up to N_CH sample FIFOs (each with registered read data, 1-cycle read latency, read ignored when empty) into one valid/ready output stream.
A channel is granted when it holds at least BURST_LEN words, or at least one word while flush is requested. The arbiter issues one read strobe per word and tags each output word with the source channel and first/last markers.
It sits between the per-channel decimator FIFOs and the shared USB/packetiser stream.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_burst_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fifo_burst_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO burst arbiter
package fifo_arb_pkg;

    // ARB: pick a channel; READ: strobe the FIFO; LATCH: capture read data;
    // SEND: present the word until the downstream accepts it.
    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_READ  = 2'd1,
        ST_LATCH = 2'd2,
        ST_SEND  = 2'd3
    } arb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick over an eligibility vector
//   elig_i  : one bit per channel, set when the channel may be granted
//   last_i  : most recently granted channel; search starts at last_i+1
//   found_o : at least one channel is eligible
//   idx_o   : first eligible channel after last_i, wrapping modulo N_CH
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IDX_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  elig_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int c;

    // Walk the offsets from farthest to nearest so the nearest eligible
    // channel after last_i is the one left in idx_o.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        c       = 0;
        for (int i = N_CH; i >= 1; i--) begin
            c = (int'(last_i) + i) % N_CH;
            if (elig_i[c[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// rtl/fifo_burst_arbiter.sv - round-robin burst drain of N_CH FIFOs into one stream
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_enable         : arbitration enable, only looked at between bursts
//   i_flush          : allow partial bursts from any non-empty FIFO
//   i_count/i_empty  : per-channel FIFO fill level and empty flag
//   i_rdata          : per-channel registered FIFO read data (1-cycle latency)
//   o_read           : one-hot FIFO read strobes
//   o_data/o_chan    : output word and its source channel
//   o_first/o_last   : burst boundary markers
//   o_valid/i_ready  : output handshake
//   o_busy           : a burst is in progress
module fifo_burst_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int FIFO_WIDTH = 8,
    parameter  int FIFO_DEPTH = 64,
    parameter  int BURST_LEN  = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int CH_W       = clog2_min1(N_CH)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic                       i_flush,
    input  logic [N_CH*CNT_W-1:0]      i_count,
    input  logic [N_CH-1:0]            i_empty,
    input  logic [N_CH*FIFO_WIDTH-1:0] i_rdata,
    output logic [N_CH-1:0]            o_read,
    output logic [FIFO_WIDTH-1:0]      o_data,
    output logic [CH_W-1:0]            o_chan,
    output logic                       o_first,
    output logic                       o_last,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_busy
);

    arb_state_t            state_q, state_d;
    logic [CH_W-1:0]       chan_q;
    logic [CH_W-1:0]       last_grant_q;
    logic [CNT_W-1:0]      remaining_q;
    logic                  first_flag_q;
    logic [FIFO_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  first_q;
    logic                  last_q;

    logic [N_CH-1:0]       elig;
    logic                  pick_found;
    logic [CH_W-1:0]       pick_idx;
    logic [CNT_W-1:0]      pick_cnt;
    logic [CNT_W-1:0]      grant_len;
    logic [FIFO_WIDTH-1:0] sel_rdata;
    logic                  grant;
    logic                  handshake;

    always_comb begin
        elig      = '0;
        pick_cnt  = '0;
        sel_rdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            elig[k] = (i_count[k*CNT_W +: CNT_W] >= CNT_W'(BURST_LEN))
                   || (i_flush && !i_empty[k]);
            if (pick_idx == CH_W'(k)) begin
                pick_cnt = i_count[k*CNT_W +: CNT_W];
            end
            if (chan_q == CH_W'(k)) begin
                sel_rdata = i_rdata[k*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (CH_W)
    ) u_rr_pick (
        .elig_i  (elig),
        .last_i  (last_grant_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // A flush burst only takes what is already in the FIFO, so the read
    // count never exceeds the contents (the fill level can only grow).
    assign grant_len = (pick_cnt >= CNT_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : pick_cnt;
    assign grant     = (state_q == ST_ARB) && i_enable && pick_found;
    assign handshake = valid_q && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (grant) state_d = ST_READ;
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: state_d = ST_SEND;
            ST_SEND: begin
                if (handshake) begin
                    state_d = (remaining_q == CNT_W'(1)) ? ST_ARB : ST_READ;
                end
            end
            default:  state_d = ST_ARB;
        endcase
    end

    always_comb begin
        o_read = '0;
        if (state_q == ST_READ) begin
            o_read = N_CH'(1) << chan_q;
        end
        o_busy = (state_q != ST_ARB);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chan_q       <= '0;
            last_grant_q <= CH_W'(N_CH - 1);
            remaining_q  <= '0;
            first_flag_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (grant) begin
                        chan_q       <= pick_idx;
                        last_grant_q <= pick_idx;
                        remaining_q  <= grant_len;
                        first_flag_q <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    data_q       <= sel_rdata;
                    valid_q      <= 1'b1;
                    first_q      <= first_flag_q;
                    last_q       <= (remaining_q == CNT_W'(1));
                    first_flag_q <= 1'b0;
                end
                ST_SEND: begin
                    if (handshake) begin
                        valid_q     <= 1'b0;
                        remaining_q <= remaining_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_data  = data_q;
    assign o_chan  = chan_q;
    assign o_first = first_q;
    assign o_last  = last_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// tb/tb_fifo_burst_arbiter.sv - scoreboard bench for fifo_burst_arbiter
module tb_fifo_burst_arbiter;

    localparam int N_CH  = 4;
    localparam int W     = 8;
    localparam int DEPTH = 64;
    localparam int BL    = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]   chan;
        logic [W-1:0] data;
        logic         first;
        logic         last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic                  flush;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH-1:0]       empty;
    logic [N_CH*W-1:0]     rdata;
    logic [N_CH-1:0]       o_read;
    logic [W-1:0]          o_data;
    logic [1:0]            o_chan;
    logic                  o_first;
    logic                  o_last;
    logic                  o_valid;
    logic                  ready;
    logic                  o_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_n  = 0;
    int last_n = 0;
    int stall_n = 0;
    int rd_cnt [N_CH] = '{default: 0};
    int acc_cyc [$];

    logic [W-1:0] fq [N_CH][$];
    logic [W-1:0] rd_q [N_CH];
    exp_t         sb [$];
    logic         stall_prev = 1'b0;
    exp_t         stall_val;

    fifo_burst_arbiter #(
        .N_CH       (N_CH),
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (DEPTH),
        .BURST_LEN  (BL)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_enable (enable),
        .i_flush  (flush),
        .i_count  (count),
        .i_empty  (empty),
        .i_rdata  (rdata),
        .o_read   (o_read),
        .o_data   (o_data),
        .o_chan   (o_chan),
        .o_first  (o_first),
        .o_last   (o_last),
        .o_valid  (o_valid),
        .i_ready  (ready),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: registered read data, one-cycle latency.
    always @(posedge clk) begin
        if (o_read != '0) begin
            checks = checks + 1;
            if ($countones(o_read) != 1) begin
                errors = errors + 1;
                $display("FAIL read_onehot o_read=%b required one-hot", o_read);
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (o_read[k]) begin
                rd_cnt[k] = rd_cnt[k] + 1;
                checks = checks + 1;
                if (fq[k].size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL read_empty ch%0d read strobe with 0 words, required >0", k);
                end else begin
                    rd_q[k] <= fq[k].pop_front();
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            count[k*CNT_W +: CNT_W] = CNT_W'(fq[k].size());
            empty[k]                = (fq[k].size() == 0);
            rdata[k*W +: W]         = rd_q[k];
        end
    end

    // Output monitor: compare accepted words against the scoreboard and
    // check that a stalled word is held unchanged.
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        act = {o_chan, o_data, o_first, o_last};
        if (!rst) begin
            if (stall_prev && o_valid) begin
                checks = checks + 1;
                if (act !== stall_val) begin
                    errors = errors + 1;
                    $display("FAIL stall_hold got %h required %h", act, stall_val);
                end
            end
            if (o_valid && ready) begin
                acc_n = acc_n + 1;
                acc_cyc.push_back(cyc);
                if (o_last) last_n = last_n + 1;
                checks = checks + 1;
                if (sb.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_word got %h required none", act);
                end else begin
                    e = sb.pop_front();
                    if (act !== e) begin
                        errors = errors + 1;
                        $display("FAIL word got chan=%0d data=%h f=%b l=%b required chan=%0d data=%h f=%b l=%b",
                                 act.chan, act.data, act.first, act.last,
                                 e.chan, e.data, e.first, e.last);
                    end
                end
            end
            if (o_valid && !ready) stall_n = stall_n + 1;
            stall_prev = o_valid && !ready;
            stall_val  = act;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int ch, input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) fq[ch].push_back(base + W'(i));
    endtask

    task automatic expect_burst(input int ch, input logic [W-1:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.chan  = 2'(ch);
            e.data  = base + W'(i);
            e.first = (i == 0);
            e.last  = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    function automatic int total_reads();
        int s;
        s = 0;
        for (int k = 0; k < N_CH; k++) s = s + rd_cnt[k];
        return s;
    endfunction

    task automatic wait_done(input string name, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (sb.size() == 0 && !o_busy) begin
                done = 1'b1;
                break;
            end
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL %s_timeout pending=%0d busy=%b required pending=0 busy=0", name, sb.size(), o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; flush = 1'b0; ready = 1'b1;
        repeat (3) tick();
        checks = checks + 1;
        if ({o_read, o_valid, o_first, o_last} !== 7'b0) begin
            errors = errors + 1;
            $display("FAIL reset_ctrl got read=%b v=%b f=%b l=%b required 0", o_read, o_valid, o_first, o_last);
        end
        checks = checks + 1;
        if ({o_data, o_chan, o_busy} !== 11'b0) begin
            errors = errors + 1;
            $display("FAIL reset_data got data=%h chan=%0d busy=%b required 0", o_data, o_chan, o_busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int r0;
        int bad;
        fill(2, 8'h20, 16);
        expect_burst(2, 8'h20, 16);
        r0 = rd_cnt[2];
        acc_cyc.delete();
        enable = 1'b1;
        wait_done("single", 300);
        checks = checks + 1;
        if (rd_cnt[2] - r0 != 16) begin
            errors = errors + 1;
            $display("FAIL single_reads got %0d required 16", rd_cnt[2] - r0);
        end
        checks = checks + 1;
        if (acc_cyc.size() != 16) begin
            errors = errors + 1;
            $display("FAIL single_count got %0d required 16", acc_cyc.size());
        end else begin
            bad = 0;
            for (int i = 1; i < 16; i++) if (acc_cyc[i] - acc_cyc[i-1] != 3) bad = bad + 1;
            checks = checks + 1;
            if (bad != 0) begin
                errors = errors + 1;
                $display("FAIL single_spacing got %0d gaps not 3 required 0", bad);
            end
        end
    endtask

    task automatic test_two_channels();
        int l0;
        fill(0, 8'h00, 32);
        fill(1, 8'h80, 32);
        expect_burst(0, 8'h00, 16);
        expect_burst(1, 8'h80, 16);
        expect_burst(0, 8'h10, 16);
        expect_burst(1, 8'h90, 16);
        l0 = last_n;
        wait_done("two", 800);
        checks = checks + 1;
        if (last_n - l0 != 4) begin
            errors = errors + 1;
            $display("FAIL two_last_count got %0d required 4", last_n - l0);
        end
    endtask

    task automatic test_flush();
        int r0;
        fill(3, 8'h30, 5);
        expect_burst(3, 8'h30, 5);
        r0 = total_reads();
        repeat (100) tick();
        checks = checks + 1;
        if (total_reads() != r0 || sb.size() != 5) begin
            errors = errors + 1;
            $display("FAIL flush_idle got reads=%0d pending=%0d required reads=0 pending=5", total_reads() - r0, sb.size());
        end
        flush = 1'b1;
        wait_done("flush", 100);
        checks = checks + 1;
        if (o_busy !== 1'b0 || o_last !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL flush_end got busy=%b last=%b required busy=0 last=1", o_busy, o_last);
        end
        flush = 1'b0;
    endtask

    task automatic test_backpressure();
        int a0;
        bit done;
        fill(1, 8'h60, 16);
        expect_burst(1, 8'h60, 16);
        a0 = acc_n;
        stall_n = 0;
        done = 1'b0;
        for (int i = 0; i < 800; i++) begin
            ready = ((i / 2) % 2) == 0;
            tick();
            if (sb.size() == 0 && !o_busy) begin
                done = 1'b1;
                break;
            end
        end
        ready = 1'b1;
        checks = checks + 1;
        if (!done || acc_n - a0 != 16) begin
            errors = errors + 1;
            $display("FAIL bp_delivered got %0d required 16", acc_n - a0);
        end
        checks = checks + 1;
        if (stall_n == 0) begin
            errors = errors + 1;
            $display("FAIL bp_stalls got 0 stalled cycles required >0");
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        exp_t e;
        fill(0, 8'h40, 16);
        for (int i = 0; i < 6; i++) begin
            e.chan = 2'd0; e.data = 8'h40 + W'(i); e.first = (i == 0); e.last = 1'b0;
            sb.push_back(e);
        end
        a0 = acc_n;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc_n - a0 >= 6) break;
        end
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_valid) break;
            tick();
        end
        checks = checks + 1;
        if (o_valid !== 1'b1 || o_data !== 8'h46) begin
            errors = errors + 1;
            $display("FAIL mid_seventh got v=%b data=%h required v=1 data=46", o_valid, o_data);
        end
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if ({o_read, o_valid, o_first, o_last, o_data, o_chan, o_busy} !== 18'b0) begin
            errors = errors + 1;
            $display("FAIL mid_reset got read=%b v=%b f=%b l=%b data=%h chan=%0d busy=%b required 0",
                     o_read, o_valid, o_first, o_last, o_data, o_chan, o_busy);
        end
        checks = checks + 1;
        if (sb.size() != 0 || fq[0].size() != 9) begin
            errors = errors + 1;
            $display("FAIL mid_progress got pending=%0d left=%0d required pending=0 left=9", sb.size(), fq[0].size());
        end
        tick();
        rst = 1'b0;
        ready = 1'b1;
        expect_burst(0, 8'h47, 9);
        flush = 1'b1;
        wait_done("mid_resume", 200);
        flush = 1'b0;
    endtask

    task automatic test_enable();
        int r0;
        enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < N_CH; k++) fill(k, W'(8'h80 + k * 16), 16);
        for (int k = 0; k < N_CH; k++) expect_burst(k, W'(8'h80 + k * 16), 16);
        r0 = total_reads();
        repeat (50) tick();
        checks = checks + 1;
        if (total_reads() != r0 || o_busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL enable_off got reads=%0d busy=%b required reads=0 busy=0", total_reads() - r0, o_busy);
        end
        enable = 1'b1;
        wait_done("enable", 800);
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_channels();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_enable();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
